// File: rtl/spi_line_fetcher.sv
// spi_line_fetcher: runs one SPI/QSPI flash read burst (CMD, ADDR, optional
// DUMMY, DATA) per start request and keeps the returned units in a line buffer
// that the display side indexes combinationally.
// Optional feature: define SPI_LINE_FETCHER_DOUBLE_BUF_EN for ping-pong banks.
module spi_line_fetcher #(
  parameter int         BUF_UNITS    = 136,
  parameter int         ADDR_BITS    = 24,
  parameter int         DUMMY_CYCLES = 8,
  parameter logic [7:0] CMD_SINGLE   = 8'h03,
  parameter logic [7:0] CMD_QUAD     = 8'h6B
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         quad,
  input  logic [ADDR_BITS-1:0]         addr,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  input  logic [$clog2(BUF_UNITS)-1:0] rd_index,
  output logic [3:0]                   rd_data,
  output logic                         rd_bank,
  output logic                         spi_cs,
  output logic                         spi_sclk,
  input  logic [3:0]                   spi_in,
  output logic                         spi_out0,
  output logic                         spi_dir0
);

  localparam int IW    = $clog2(BUF_UNITS);
  localparam int MAX_A = (ADDR_BITS > DUMMY_CYCLES) ? ADDR_BITS : DUMMY_CYCLES;
  localparam int MAX_B = (MAX_A > BUF_UNITS) ? MAX_A : BUF_UNITS;
  localparam int MAX_C = (MAX_B > 8) ? MAX_B : 8;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int SW    = 8 + ADDR_BITS;

  localparam logic [CW-1:0] CMD_LAST   = CW'(7);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(BUF_UNITS - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(BUF_UNITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          quad_q, quad_d;
  logic          done_q, done_d;
  logic [3:0]    unit_w;

  assign spi_sclk = ~clk;
  assign busy     = (state_q != S_IDLE);
  assign spi_cs   = busy;
  assign done     = done_q;
  // Command and address leave MSB-first from the top of one shift register.
  assign spi_out0 = ((state_q == S_CMD) || (state_q == S_ADDR)) ? sh_q[SW-1] : 1'b0;
  assign spi_dir0 = quad_q && ((state_q == S_DUMMY) || (state_q == S_DATA));
  assign unit_w   = quad_q ? spi_in : {3'b000, spi_in[1]};

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      quad_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      quad_q  <= quad_d;
      done_q  <= done_d;
    end
  end

  // Burst sequencing; abort overrides everything except a start from idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sh_d    = sh_q;
    quad_d  = quad_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_CMD;
          quad_d  = quad;
          sh_d    = {(quad ? CMD_QUAD : CMD_SINGLE), addr};
        end
      end
      S_CMD: begin
        sh_d = sh_q << 1;
        if (cnt_q == CMD_LAST) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        sh_d = sh_q << 1;
        if (cnt_q == ADDR_LAST) begin
          state_d = (quad_q && (DUMMY_CYCLES != 0)) ? S_DUMMY : S_DATA;
          cnt_d   = '0;
        end
      end
      S_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

`ifdef SPI_LINE_FETCHER_DOUBLE_BUF_EN
  logic [3:0] mem_q [2][BUF_UNITS];
  logic       bank_q;

  // Displayed bank flips only when a complete line has just landed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bank_q <= 1'b0;
    else if (done_d) bank_q <= ~bank_q;
  end

  // Capture each unit into the hidden bank at rising SCLK (falling clk).
  always_ff @(negedge clk) begin
    if (state_q == S_DATA) mem_q[~bank_q][cnt_q[IW-1:0]] <= unit_w;
  end

  // Display read of the presented bank; out-of-range indices read zero.
  always_comb begin
    rd_data = 4'h0;
    if (rd_index <= IDX_MAX) rd_data = mem_q[bank_q][rd_index];
  end

  assign rd_bank = bank_q;
`else
  logic [3:0] mem_q [BUF_UNITS];

  // Capture each unit at rising SCLK (falling clk); display may see it at once.
  always_ff @(negedge clk) begin
    if (state_q == S_DATA) mem_q[cnt_q[IW-1:0]] <= unit_w;
  end

  // Display read; out-of-range indices read zero.
  always_comb begin
    rd_data = 4'h0;
    if (rd_index <= IDX_MAX) rd_data = mem_q[rd_index];
  end

  assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_spi_line_fetcher.sv
// Bench for spi_line_fetcher: flash model driven cycle by cycle, scoreboard
// queues for MOSI bits and captured line units.
`timescale 1ns/1ps
module tb_spi_line_fetcher;

  localparam int BUF = 136;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          quad = 1'b0;
  logic          abort = 1'b0;
  logic [23:0]   addr = '0;
  logic [IW-1:0] rd_index = '0;
  logic [3:0]    spi_in = '0;
  logic          busy, done, rd_bank, spi_cs, spi_sclk, spi_out0, spi_dir0;
  logic [3:0]    rd_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mosi_q[$];
  logic [3:0] exp_q[$];
  int         rd_ptr = 0;
  logic       exp_bank = 1'b0;
  bit         have_prev = 1'b0;
  logic [3:0] prev3 = '0;

  always #5 clk = ~clk;

  spi_line_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .quad(quad), .addr(addr),
    .abort(abort), .busy(busy), .done(done), .rd_index(rd_index),
    .rd_data(rd_data), .rd_bank(rd_bank), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_in(spi_in), .spi_out0(spi_out0), .spi_dir0(spi_dir0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash data pattern: 0/3 single (A5/5A bytes MSB-first), 1/2 quad nibbles.
  function automatic logic [3:0] unit_val(input int pat, input int k);
    logic [7:0] b;
    case (pat)
      0: begin b = 8'hA5; return {3'b000, b[7 - (k % 8)]}; end
      3: begin b = 8'h5A; return {3'b000, b[7 - (k % 8)]}; end
      1: return 4'(k % 16);
      default: return 4'(15 - (k % 16));
    endcase
  endfunction

  // Called at a negedge with clk low; drives start and follows the burst.
  task automatic run_burst(input bit q, input logic [23:0] a, input int abort_at,
                           input int busy_start_at, input bit with_abort, input int pat);
    int dstart, total, end_c, c, k, cs_cnt, done_cnt, dir_first;
    logic [7:0]  cmd;
    logic [3:0]  v;
    logic [31:0] r;
    dstart = q ? 40 : 32;
    total  = dstart + BUF;
    end_c  = (abort_at >= 0) ? dstart + abort_at + 1 : total + 1;
    cmd    = q ? 8'h6B : 8'h03;
    for (int i = 0; i < 8; i++)  mosi_q.push_back(cmd[7-i]);
    for (int i = 0; i < 24; i++) mosi_q.push_back(a[23-i]);
    start = 1'b1; quad = q; addr = a; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    c = 0; cs_cnt = 0; done_cnt = 0; dir_first = -1;
    forever begin
      if (spi_cs) cs_cnt++;
      if (done) done_cnt++;
      if (spi_dir0 && dir_first < 0) dir_first = c;
      if (c == 0) begin
        chk("cs_first", spi_cs, 1);
        chk("busy_first", busy, 1);
      end
      if (c < 32) chk("mosi", spi_out0, mosi_q.pop_front());
      if (c == dstart) chk("mosi_data", spi_out0, 0);
      if (c >= 1 && c < 32 && exp_q.size() > 0) begin
        rd_index = IW'(rd_ptr); #1;
        chk("kept", rd_data, exp_q.pop_front());
        rd_ptr++;
      end
`ifdef SPI_LINE_FETCHER_DOUBLE_BUF_EN
      if (c == total - 1 && have_prev) begin
        rd_index = 8'd3; #1;
        chk("stable", rd_data, prev3);
      end
`endif
      if (abort_at < 0 && c == total) begin
        chk("done_end", done, 1);
        chk("cs_end", spi_cs, 0);
        chk("busy_end", busy, 0);
        chk("dir_end", spi_dir0, 0);
      end
      if (abort_at >= 0 && c == end_c) begin
        chk("cs_abort", spi_cs, 0);
        chk("busy_abort", busy, 0);
        chk("dir_abort", spi_dir0, 0);
      end
      if (c == end_c) begin
        start = 1'b0; abort = 1'b0;
        break;
      end
      start = (c == busy_start_at);
      abort = (abort_at >= 0 && c == dstart + abort_at);
      if (start) begin quad = ~q; addr = 24'hFFFFFF; end
      @(posedge clk); #1;
      c++;
      if (c >= dstart && c < total) begin
        k = c - dstart;
        v = unit_val(pat, k);
        r = $urandom;
        spi_in = q ? v : {r[3:2], v[0], r[0]};
        if (abort_at < 0 || k < abort_at) exp_q.push_back(v);
      end
      @(negedge clk);
    end
    chk("cs_cycles", cs_cnt, (abort_at >= 0) ? end_c : total);
    chk("done_count", done_cnt, (abort_at >= 0) ? 0 : 1);
    chk("dir_first", dir_first, q ? 32 : -1);
    rd_ptr = 0;
`ifdef SPI_LINE_FETCHER_DOUBLE_BUF_EN
    if (abort_at < 0) exp_bank = ~exp_bank;
    else exp_q.delete();
`endif
    chk("rd_bank", rd_bank, exp_bank);
  endtask

  // Read back a completed line, then realign to a negedge.
  task automatic readback();
    int n;
    logic [3:0] v;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      rd_index = IW'(k); #1;
      v = exp_q.pop_front();
      if (k == 3) prev3 = v;
      chk("line", rd_data, v);
    end
    have_prev = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", spi_cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out0", spi_out0, 0);
    chk("rst_dir0", spi_dir0, 0);
    chk("rst_bank", rd_bank, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_burst(1'b0, 24'h000450, -1, 5, 1'b0, 0);
    readback();
    run_burst(1'b1, 24'h000800, -1, -1, 1'b0, 1);
    readback();
    run_burst(1'b1, 24'h000123, 10, -1, 1'b0, 2);
    run_burst(1'b0, 24'h00ABCD, -1, -1, 1'b1, 3);
    readback();

    start = 1'b1; quad = 1'b1; addr = 24'h5A5A5A;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cs", spi_cs, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_out0", spi_out0, 0);
    chk("arst_dir0", spi_dir0, 0);
    chk("arst_bank", rd_bank, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_bank = 1'b0;
    have_prev = 1'b0;

    run_burst(1'b1, 24'h000900, -1, -1, 1'b0, 2);
    readback();
    run_burst(1'b0, 24'h000450, -1, -1, 1'b0, 0);
    readback();

    rd_index = 8'd136; #1;
    chk("oob_136", rd_data, 0);
    rd_index = 8'd255; #1;
    chk("oob_255", rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
